lcd_cmd_sequencer: RTL and testbench

- Controller that owns the HD44780-style character LCD bus (RS, E, DB7..DB4) in 4-bit mode on the 100 MHz fabric clock.
- After reset it runs the power-on initialisation autonomously.
- It then accepts command/data bytes from one upstream requester over a valid/ready handshake.
- Each byte is sent as two nibbles with correct E timing and execution delays; it replaces hard-wired one-shot nibble senders.

---
 rtl/lcd_cmd_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_lcd_cmd_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_sequencer.sv
// HD44780-style 4-bit LCD bus owner: runs the power-on init, then writes upstream
// command/data bytes as high/low nibble strobes followed by an execution wait.
module lcd_cmd_sequencer #(
  parameter int T_POWERUP = 4_000_000,
  parameter int T_INIT_A  = 410_000,
  parameter int T_INIT_B  = 10_000,
  parameter int T_SETUP   = 4,
  parameter int T_E_HIGH  = 50,
  parameter int T_E_LOW   = 100,
  parameter int T_SHORT   = 3_700,
  parameter int T_LONG    = 152_000
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  output logic       busy,
  output logic       RS,
  output logic       E,
  output logic       DB7,
  output logic       DB6,
  output logic       DB5,
  output logic       DB4,
  output logic [3:0] dbg_state
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX = max2(max2(max2(T_POWERUP, T_INIT_A), max2(T_INIT_B, T_SETUP)),
                              max2(max2(T_E_HIGH, T_E_LOW), max2(T_SHORT, T_LONG)));
  localparam int CW = $clog2(T_MAX + 1);
  localparam logic [2:0] N_INIT_BYTES = 3'd5;

  typedef enum logic [3:0] {
    PWR_WAIT, INIT_NIB, INIT_WAIT, INIT_BYTES, IDLE, SETUP, E_HI, E_LO, EXEC_WAIT
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [1:0]      nib_idx;
  logic [2:0]      byte_idx;
  logic            init_nib;
  logic            lo_phase;
  logic            cur_rs;
  logic [7:0]      cur_byte;
  logic [3:0]      db;

  assign {DB7, DB6, DB5, DB4} = db;
  assign dbg_state = state;

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h28;
      3'd1:    return 8'h08;
      3'd2:    return 8'h01;
      3'd3:    return 8'h06;
      default: return 8'h0C;
    endcase
  endfunction

  // Clear and return-home (0x01..0x03 as commands) need the long execution time.
  function automatic logic [CW-1:0] exec_len(input logic rs, input logic [7:0] b);
    if (!rs && (b == 8'h01 || b == 8'h02 || b == 8'h03))
      return CW'(T_LONG - 1);
    return CW'(T_SHORT - 1);
  endfunction

  // Valid/ready: a byte transfers on any clock edge where req_valid && req_ready;
  // req_ready is only high while idle after init, and drops the cycle after a transfer.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= PWR_WAIT;
      cnt       <= '0;
      nib_idx   <= '0;
      byte_idx  <= '0;
      init_nib  <= 1'b1;
      lo_phase  <= 1'b0;
      cur_rs    <= 1'b0;
      cur_byte  <= '0;
      db        <= '0;
      RS        <= 1'b0;
      E         <= 1'b0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (state)
        // Counter starts cleared out of reset, so the power-up wait counts up.
        PWR_WAIT: begin
          if (cnt == CW'(T_POWERUP - 1)) begin
            db    <= 4'h3;
            RS    <= 1'b0;
            cnt   <= CW'(T_SETUP - 1);
            state <= INIT_NIB;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        INIT_NIB, SETUP: begin
          if (cnt == '0) begin
            E     <= 1'b1;
            cnt   <= CW'(T_E_HIGH - 1);
            state <= E_HI;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        E_HI: begin
          if (cnt == '0) begin
            E <= 1'b0;
            if (init_nib) begin
              cnt   <= (nib_idx == 2'd0) ? CW'(T_INIT_A - 1) : CW'(T_INIT_B - 1);
              state <= INIT_WAIT;
            end else if (!lo_phase) begin
              cnt   <= CW'(T_E_LOW - 1);
              state <= E_LO;
            end else begin
              cnt   <= exec_len(cur_rs, cur_byte);
              state <= EXEC_WAIT;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        INIT_WAIT: begin
          if (cnt == '0) begin
            if (nib_idx == 2'd3) begin
              init_nib <= 1'b0;
              state    <= INIT_BYTES;
            end else begin
              nib_idx <= nib_idx + 2'd1;
              db      <= (nib_idx == 2'd2) ? 4'h2 : 4'h3;
              cnt     <= CW'(T_SETUP - 1);
              state   <= INIT_NIB;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        INIT_BYTES: begin
          cur_rs   <= 1'b0;
          cur_byte <= init_byte(byte_idx);
          RS       <= 1'b0;
          db       <= init_byte(byte_idx)[7:4];
          lo_phase <= 1'b0;
          byte_idx <= byte_idx + 3'd1;
          cnt      <= CW'(T_SETUP - 1);
          state    <= SETUP;
        end
        IDLE: begin
          if (req_valid && req_ready) begin
            cur_rs    <= req_rs;
            cur_byte  <= req_data;
            RS        <= req_rs;
            db        <= req_data[7:4];
            lo_phase  <= 1'b0;
            cnt       <= CW'(T_SETUP - 1);
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        E_LO: begin
          if (cnt == '0) begin
            db       <= cur_byte[3:0];
            lo_phase <= 1'b1;
            cnt      <= CW'(T_SETUP - 1);
            state    <= SETUP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        EXEC_WAIT: begin
          if (cnt == '0) begin
            if (byte_idx == N_INIT_BYTES) begin
              req_ready <= 1'b1;
              busy      <= 1'b0;
              init_done <= 1'b1;
              state     <= IDLE;
            end else begin
              state <= INIT_BYTES;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= PWR_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Bench for lcd_cmd_sequencer: randomized byte stream, expected LCD strobes queued
// by a timing model and checked by an independent bus monitor.
module tb_lcd_cmd_sequencer;

  localparam int T_POWERUP = 20;
  localparam int T_INIT_A  = 10;
  localparam int T_INIT_B  = 5;
  localparam int T_SETUP   = 2;
  localparam int T_E_HIGH  = 3;
  localparam int T_E_LOW   = 4;
  localparam int T_SHORT   = 8;
  localparam int T_LONG    = 30;
  localparam int BUDGET    = 2000;

  // One expected strobe: gap from previous E fall (or reset release) to E rise,
  // whether that gap is exact or a minimum, ready delay after this strobe's fall.
  typedef struct packed {
    logic        exact;
    logic [15:0] gap;
    logic [15:0] rdy;
    logic        rs;
    logic [3:0]  nib;
  } exp_t;
  localparam int W = $bits(exp_t);

  logic       clk, nrst, req_valid, req_rs;
  logic [7:0] req_data;
  logic       req_ready, init_done, busy, RS, E, DB7, DB6, DB5, DB4;
  logic [3:0] dbg_state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int last_exec = 0;

  lcd_cmd_sequencer #(
    .T_POWERUP(T_POWERUP), .T_INIT_A(T_INIT_A), .T_INIT_B(T_INIT_B), .T_SETUP(T_SETUP),
    .T_E_HIGH(T_E_HIGH), .T_E_LOW(T_E_LOW), .T_SHORT(T_SHORT), .T_LONG(T_LONG)
  ) dut (
    .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_rs(req_rs), .req_data(req_data),
    .req_ready(req_ready), .init_done(init_done), .busy(busy), .RS(RS), .E(E),
    .DB7(DB7), .DB6(DB6), .DB5(DB5), .DB4(DB4), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- helpers / model ----------------
  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (state %0d)", name, act, expv, dbg_state);
    end
  endtask

  function automatic int exec_len(input logic rs, input logic [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? T_LONG : T_SHORT;
  endfunction

  task automatic push_ent(input logic exact, input int gap, input int rdy,
                          input logic rs, input logic [3:0] nib);
    exp_t e;
    e.exact = exact;
    e.gap   = 16'(gap);
    e.rdy   = 16'(rdy);
    e.rs    = rs;
    e.nib   = nib;
    exp_q.push_back(e);
  endtask

  // A byte starts one load cycle plus setup after the previous wait ends.
  task automatic push_byte(input logic rs, input logic [7:0] d, input logic exact, input logic rdy_en);
    push_ent(exact, last_exec + 1 + T_SETUP, 0, rs, d[7:4]);
    push_ent(1'b1, T_E_LOW + T_SETUP, rdy_en ? exec_len(rs, d) : 0, rs, d[3:0]);
    last_exec = exec_len(rs, d);
  endtask

  task automatic push_init();
    int waits[4];
    logic [3:0] nibs[4];
    logic [7:0] bytes[5];
    int gap;
    waits = '{T_INIT_A, T_INIT_B, T_INIT_B, T_INIT_B};
    nibs  = '{4'h3, 4'h3, 4'h3, 4'h2};
    bytes = '{8'h28, 8'h08, 8'h01, 8'h06, 8'h0C};
    gap = T_POWERUP + T_SETUP;
    for (int i = 0; i < 4; i++) begin
      push_ent(1'b1, gap, 0, 1'b0, nibs[i]);
      gap = waits[i] + T_SETUP;
    end
    last_exec = waits[3];
    for (int i = 0; i < 5; i++) push_byte(1'b0, bytes[i], 1'b1, i == 4);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    nrst = 1'b0;
    #1;
    exp_q.delete();
    chk("rst_E", int'(E), 0);
    chk("rst_RS", int'(RS), 0);
    chk("rst_DB", int'({DB7, DB6, DB5, DB4}), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_init_done", int'(init_done), 0);
    chk("rst_busy", int'(busy), 1);
    repeat (3) @(negedge clk);
    #1 nrst = 1'b1;
    push_init();
  endtask

  task automatic send_byte(input logic rs, input logic [7:0] d, input logic b2b);
    int n;
    if (!b2b) repeat ($urandom_range(0, 6)) @(posedge clk);
    push_byte(rs, d, b2b, 1'b1);
    @(posedge clk);
    #1;
    req_rs    = rs;
    req_data  = d;
    req_valid = 1'b1;
    n = 0;
    while (n < BUDGET) begin
      @(negedge clk);
      if (req_ready) break;
      n++;
    end
    if (n >= BUDGET) chk("handshake_timeout", n, 0);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  int         cyc, hi_cnt, rdy_wait, rdy_cnt;
  logic       e_prev, acc_pend, stab_err, have_cur, ok;
  logic [4:0] bus, hold_val;
  logic [4:0] hist[T_SETUP];
  exp_t       cur;

  initial begin
    cyc = 0; hi_cnt = 0; rdy_wait = 0; rdy_cnt = 0;
    e_prev = 1'b0; acc_pend = 1'b0; stab_err = 1'b0; have_cur = 1'b0;
    hold_val = '0;
    for (int i = 0; i < T_SETUP; i++) hist[i] = '0;
    forever begin
      @(negedge clk);
      bus = {RS, DB7, DB6, DB5, DB4};
      if (!nrst) begin
        cyc = 0; hi_cnt = 0; rdy_wait = 0; rdy_cnt = 0;
        e_prev = 1'b0; acc_pend = 1'b0; stab_err = 1'b0; have_cur = 1'b0;
      end else begin
        cyc++;
        if (acc_pend) begin
          chk("accept_drops_ready", int'(req_ready), 0);
          chk("accept_sets_busy", int'(busy), 1);
        end
        acc_pend = req_valid && req_ready;
        if (req_valid && !init_done) chk("ready_during_init", int'(req_ready), 0);
        if (rdy_wait != 0) begin
          rdy_cnt++;
          if (req_ready) begin
            chk("exec_wait_len", rdy_cnt, rdy_wait);
            chk("idle_busy", int'(busy), 0);
            chk("idle_init_done", int'(init_done), 1);
            rdy_wait = 0;
          end else if (rdy_cnt > rdy_wait + 4) begin
            chk("exec_wait_timeout", rdy_cnt, rdy_wait);
            rdy_wait = 0;
          end
        end
        if (E && !e_prev) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: got nibble %0h expected none", bus[3:0]);
            have_cur = 1'b0;
          end else begin
            cur = exp_q.pop_front();
            have_cur = 1'b1;
            chk("strobe_rs", int'(bus[4]), int'(cur.rs));
            chk("strobe_nibble", int'(bus[3:0]), int'(cur.nib));
            if (cur.exact) begin
              chk("strobe_gap", cyc, int'(cur.gap));
            end else begin
              checks++;
              if (cyc < int'(cur.gap)) begin
                errors++;
                $display("FAIL strobe_gap_min: got %0d expected at least %0d", cyc, cur.gap);
              end
            end
            ok = 1'b1;
            for (int i = 0; i < T_SETUP; i++) if (hist[i] != bus) ok = 1'b0;
            chk("setup_stable", int'(ok), 1);
          end
          hold_val = bus;
          hi_cnt   = 1;
          stab_err = 1'b0;
        end else if (E && e_prev) begin
          hi_cnt++;
          if (bus != hold_val) stab_err = 1'b1;
        end else if (!E && e_prev) begin
          chk("e_high_width", hi_cnt, T_E_HIGH);
          chk("hold_stable", int'(!stab_err && bus == hold_val), 1);
          cyc = 0;
          if (have_cur && cur.rdy != 0) begin
            rdy_wait = int'(cur.rdy);
            rdy_cnt  = 0;
          end
          have_cur = 1'b0;
        end
        for (int i = T_SETUP - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = bus;
        e_prev = E;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [7:0] d;
    nrst = 1'b1; req_valid = 1'b0; req_rs = 1'b0; req_data = '0;
    #1;
    do_reset();

    // valid held during init: accepted in the first idle cycle
    send_byte(1'b1, 8'h41, 1'b1);
    // clear then back-to-back set-address: long wait then exact gap
    send_byte(1'b0, 8'h01, 1'b0);
    send_byte(1'b0, 8'h80, 1'b1);

    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) d = 8'($urandom_range(1, 3));
      send_byte(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)));
    end

    // reset while E is high in the middle of a byte
    send_byte(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    n = 0;
    while (!E && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk("e_high_before_reset", int'(E), 1);
    #2;
    do_reset();

    send_byte(1'b1, 8'h48, 1'b1);
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) d = 8'($urandom_range(1, 3));
      send_byte(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)));
    end

    n = 0;
    while ((exp_q.size() != 0 || rdy_wait != 0 || E) && n < 2 * BUDGET) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
